icache: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction fetch unit and the byte-serial memory controller. Fetch hits return in the request cycle. A miss refills a whole line with four consecutive word reads, issued through the memory controller's valid/ready handshake. All other memory clients reach the controller through a separate path; this block only reads.

---
 rtl/icache_if.sv | 26 ++
 rtl/icache.sv | 120 ++++++++++++
 tb/tb_icache.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-controller-side signal bundle for icache
interface icache_if;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [1:0]  mc_len;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [31:0] mc_res;

    // cache side: answers fetches, issues memory reads
    modport slave (
        input  if_valid, if_addr, mc_ready, mc_res,
        output if_ready, if_inst, mc_valid, mc_wr, mc_addr, mc_len, mc_data
    );

    // environment side: fetch unit plus memory controller
    modport master (
        output if_valid, if_addr, mc_ready, mc_res,
        input  if_ready, if_inst, mc_valid, mc_wr, mc_addr, mc_len, mc_data
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with 4-word line refill
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [TAG_W-1:0]        fill_tag_q, fill_tag_d;
    logic [INDEX_BITS-1:0]   fill_idx_q, fill_idx_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    mc_valid_q, mc_valid_d;

    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES*4];

    logic                    tag_we;
    logic                    data_we;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [1:0]              req_word;
    logic                    hit;
    logic                    unused_ok;

    assign req_idx   = bus.if_addr[INDEX_BITS+3:4];
    assign req_tag   = bus.if_addr[31:INDEX_BITS+4];
    assign req_word  = bus.if_addr[3:2];
    assign unused_ok = ^bus.if_addr[1:0];

    // A line being refilled has its valid bit cleared, so it can never hit mid-fill
    assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign bus.if_ready = rdy_in && bus.if_valid && hit;
    assign bus.if_inst  = data_mem[{req_idx, req_word}];

    // Memory request is fully determined by registered fill state, so it is stable while waiting
    assign bus.mc_valid = mc_valid_q;
    assign bus.mc_wr    = 1'b0;
    assign bus.mc_addr  = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
    assign bus.mc_len   = 2'b10;
    assign bus.mc_data  = 32'h0;

    // Next-state logic: start a fill on an IDLE miss, step through words 0..3 on mc_ready
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        valid_d    = valid_q;
        mc_valid_d = mc_valid_q;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (bus.if_valid && !hit) begin
                        state_d          = FILL;
                        fill_tag_d       = req_tag;
                        fill_idx_d       = req_idx;
                        cnt_d            = 2'd0;
                        valid_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        mc_valid_d       = 1'b1;
                    end
                end
                FILL: begin
                    if (bus.mc_ready) begin
                        data_we = 1'b1;
                        if (cnt_q == 2'd3) begin
                            valid_d[fill_idx_q] = 1'b1;
                            state_d             = IDLE;
                            mc_valid_d          = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state and registered memory-request valid; reset abandons any fill
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            valid_q    <= '0;
            mc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            valid_q    <= valid_d;
            mc_valid_q <= mc_valid_d;
        end
    end

    // Tag and data storage; contents are only trusted through the valid bits
    always_ff @(posedge clk_in) begin
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
        if (data_we) begin
            data_mem[{fill_idx_q, cnt_q}] <= bus.mc_res;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized and directed checks of icache against a line-level model
module tb_icache;
    localparam int IB = 4;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    icache_if bus();

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: which lines hold which tag, and the reads still owed for the pending fill
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_q     [$];
    int          m_fidx;

    // responder bookkeeping
    int          done_cnt = 0;
    logic [31:0] done_q [$];
    bit          consumed;
    int          lat;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return {a[15:0] ^ 16'hBEEF, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: check outputs against the model, then advance the model for the coming edge
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                m_q.delete();
                chk("rst_mc_valid", {31'b0, bus.mc_valid}, 32'd0);
                chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd0);
            end else begin
                int          idx;
                logic [23:0] tg;
                bit          mhit;
                idx  = int'(bus.if_addr[7:4]);
                tg   = bus.if_addr[31:8];
                mhit = m_valid[idx] && (m_tag[idx] == tg);
                chk("if_ready", {31'b0, bus.if_ready}, {31'b0, rdy_in && bus.if_valid && mhit});
                if (rdy_in && bus.if_valid && mhit)
                    chk("if_inst", bus.if_inst, mem_word(bus.if_addr));
                chk("mc_valid", {31'b0, bus.mc_valid}, {31'b0, m_q.size() != 0});
                if (m_q.size() != 0) begin
                    chk("mc_addr", bus.mc_addr, m_q[0]);
                    chk("mc_wr", {31'b0, bus.mc_wr}, 32'd0);
                    chk("mc_len", {30'b0, bus.mc_len}, 32'd2);
                    chk("mc_data", bus.mc_data, 32'd0);
                end
                if (rdy_in) begin
                    if (m_q.size() == 0) begin
                        if (bus.if_valid && !mhit) begin
                            m_valid[idx] = 1'b0;
                            m_tag[idx]   = tg;
                            m_fidx       = idx;
                            for (int w = 0; w < 4; w++)
                                m_q.push_back({tg, idx[3:0], w[1:0], 2'b00});
                        end
                    end else if (bus.mc_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_valid[m_fidx] = 1'b1;
                    end
                end
            end
        end
    end

    // memory controller stand-in: random 0..3 cycle latency per word
    initial begin
        bus.mc_ready = 1'b0;
        bus.mc_res   = 32'h0;
        lat          = 0;
        forever begin
            @(negedge clk_in);
            consumed = rst_in && rdy_in && bus.mc_valid && bus.mc_ready;
            if (consumed) begin
                done_cnt++;
                done_q.push_back(bus.mc_addr);
            end
            @(posedge clk_in);
            #2;
            if (!rst_in || !bus.mc_valid) begin
                bus.mc_ready = 1'b0;
                lat = $urandom_range(0, 3);
            end else begin
                if (consumed) begin
                    bus.mc_ready = 1'b0;
                    lat = $urandom_range(0, 3);
                end
                if (!bus.mc_ready) begin
                    if (lat == 0) begin
                        bus.mc_ready = 1'b1;
                        bus.mc_res   = mem_word(bus.mc_addr);
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        bus.if_valid = 1'b0;
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int n);
        int target;
        int t;
        target = done_cnt + n;
        t = 0;
        while (done_cnt < target && t < 100) begin
            tick();
            t++;
        end
        chk("wait_mc_ready", {31'b0, done_cnt >= target}, 32'd1);
    endtask

    task automatic chk_line0_seq(input string name, input logic [31:0] base);
        chk(name, {28'b0, done_q.size() >= 4 ? 4'd4 : 4'(done_q.size())}, 32'd4);
        if (done_q.size() >= 4)
            for (int i = 0; i < 4; i++)
                chk(name, done_q[i], base + 32'(4 * i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_addr  = 32'h0;
        do_reset();
        #1;
        chk("reset_mc_valid", {31'b0, bus.mc_valid}, 32'd0);
        chk("reset_if_ready", {31'b0, bus.if_ready}, 32'd0);

        // cold miss at 0
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0;
        done_q.delete();
        wait_done(4);
        chk_line0_seq("cold_seq", 32'h0);
        chk("cold_ready", {31'b0, bus.if_ready}, 32'd1);
        chk("cold_inst", bus.if_inst, 32'h11);

        // zero-latency hit on word 2
        bus.if_addr = 32'h8;
        #1;
        chk("hit8_ready", {31'b0, bus.if_ready}, 32'd1);
        chk("hit8_inst", bus.if_inst, 32'h33);
        chk("hit8_mc_valid", {31'b0, bus.mc_valid}, 32'd0);
        tick();

        // conflict on index 0
        bus.if_addr = 32'h100;
        #1;
        chk("conf_miss", {31'b0, bus.if_ready}, 32'd0);
        done_q.delete();
        wait_done(4);
        chk_line0_seq("conf_seq", 32'h100);
        bus.if_addr = 32'h0;
        #1;
        chk("conf_remiss", {31'b0, bus.if_ready}, 32'd0);
        tick();
        chk("conf_refill_valid", {31'b0, bus.mc_valid}, 32'd1);
        chk("conf_refill_addr", bus.mc_addr, 32'h0);
        wait_done(4);

        // rdy_in low for 5 cycles after 2nd word
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0;
        done_q.delete();
        wait_done(2);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_mc_valid", {31'b0, bus.mc_valid}, 32'd1);
            chk("stall_mc_addr", bus.mc_addr, 32'h8);
            chk("stall_if_ready", {31'b0, bus.if_ready}, 32'd0);
        end
        rdy_in = 1'b1;
        wait_done(2);
        chk_line0_seq("stall_seq", 32'h0);
        chk("stall_done_inst", bus.if_inst, 32'h11);

        // fetch unit drops its request after the 1st word
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0;
        done_q.delete();
        wait_done(1);
        bus.if_valid = 1'b0;
        for (int t = 0; t < 100 && bus.mc_valid; t++) begin
            chk("drop_if_ready", {31'b0, bus.if_ready}, 32'd0);
            tick();
        end
        chk("drop_fill_done", {31'b0, bus.mc_valid}, 32'd0);
        chk_line0_seq("drop_seq", 32'h0);
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h4;
        #1;
        chk("drop_hit4", {31'b0, bus.if_ready}, 32'd1);
        chk("drop_inst4", bus.if_inst, 32'h22);
        tick();

        // reset during the 3rd word read
        do_reset();
        bus.if_valid = 1'b1;
        bus.if_addr  = 32'h0;
        wait_done(2);
        tick();
        rst_in = 1'b0;
        #1;
        chk("midrst_mc_valid", {31'b0, bus.mc_valid}, 32'd0);
        chk("midrst_if_ready", {31'b0, bus.if_ready}, 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        chk("midrst_remiss", {31'b0, bus.if_ready}, 32'd0);
        done_q.delete();
        wait_done(4);
        chk_line0_seq("midrst_seq", 32'h0);
        chk("midrst_inst", bus.if_inst, 32'h11);

        // randomized traffic over a small address set so hits, conflicts and mid-fill changes occur
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick();
            rdy_in       = ($urandom_range(0, 9) != 0);
            bus.if_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                bus.if_addr = (32'($urandom_range(0, 2)) << 8) |
                              (32'($urandom_range(0, 3)) << 4) |
                              (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 499) == 0) begin
                rst_in = 1'b0;
                tick();
                rst_in = 1'b1;
            end
        end
        rdy_in = 1'b1;
        bus.if_valid = 1'b0;
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
